i2c_master: RTL and testbench
=============================

// Module: i2c_master
// PURPOSE
//  Single-master I2C controller. Runs one single-byte transaction per request:
//  START, {addr,rw}, address ACK, one data byte, data ACK/NACK, STOP.
//  Drives the same open-drain SDA/SCL bus as our I2C slave and is the initiator side of that link.
//  Multi-master arbitration and clock stretching are not supported. SCL is driven, never sampled.
// PARAMETERS
//  CLK_DIV  250  clk cycles per quarter SCL period (SCL = clk/(4*CLK_DIV)); legal range >= 2
// PORTS
//  clk      in     1  system clock; all logic is posedge clk
//  reset    in     1  synchronous, active-high
//  start    in     1  request pulse; sampled only when busy=0
//  rw       in     1  0 = write, 1 = read; latched with start
//  addr     in     7  target address; latched with start
//  wdata    in     8  write byte; latched with start
//  rdata    out    8  last byte read
//  busy     out    1  transaction in progress
//  done     out    1  one-cycle pulse at the end of a transaction
//  ack_err  out    1  sticky NACK flag for the last transaction
//  SDA      inout  1  open-drain: drives 0 or z
//  SCL      inout  1  open-drain: drives 0 or z
// BEHAVIOUR
//  Reset: state=IDLE; SDA=z, SCL=z; busy=0, done=0, ack_err=0, rdata=0; counters cleared.
//  Reset mid-transaction: bus is released on the next edge with no STOP. Abort is allowed.
//  Timing base: quarter counter qcnt counts 0..CLK_DIV-1, then phase q advances 0..3.
//  Each bit slot is 4 quarters:
//    q0, q1: SCL=0; SDA is updated at the start of q0
//    q2, q3: SCL=z (high)
//    SDA is sampled on the last clk of q2
//  States:
//    IDLE: start=1 latches rw, addr, wdata; ack_err:=0; busy:=1 next cycle; go to START.
//          start while busy=1 is ignored.
//    START (4q): q0,q1 SDA=z SCL=z; q2 SDA=0 SCL=z; q3 SDA=0 SCL=0 -> ADDR.
//    ADDR (8 bits): shifts out {addr,rw} MSB first -> AACK.
//    AACK (1 bit): SDA=z.
//          sampled 0 -> DATA.
//          sampled 1 -> ack_err:=1, skip the data phase, go to STOP.
//    DATA (8 bits):
//          write: drives wdata MSB first.
//          read: SDA=z; sampled bits shift into sreg MSB first.
//    DACK (1 bit):
//          write: SDA=z; sampled 1 -> ack_err:=1.
//          read: master NACKs (SDA=z); rdata:=sreg at end of slot.
//          -> STOP.
//    STOP (4q): q0 SDA=0 SCL=0; q1 SDA=0 SCL=z; q2,q3 SDA=z SCL=z -> IDLE.
//  Completion: busy falls at the STOP->IDLE transition; done=1 for that same single cycle.
//  busy duration:
//    full transaction: 80*CLK_DIV cycles (START 4q + 18 bits*4q + STOP 4q)
//    address NACK: 44*CLK_DIV cycles
//  SDA changes only while SCL is low, except the START and STOP edges.
//  Bit counter is 3 bits and wraps 7->0 at each byte end.
//  rdata changes only on a read with address ACK. It is unchanged after writes or address NACK.
//  A new start can be accepted in the cycle done is high: busy=0 there, so the request is sampled.
// TESTING (CLK_DIV=4 unless stated)
//  1 Write addr=0x50, wdata=0xA5, slave model ACKs both:
//    -> SCL-high samples A0 then A5; ack_err=0; busy high 320 cycles; done pulse 1 cycle.
//  2 Read addr=0x50, slave returns 0x3C:
//    -> bus shows A1; master NACKs the data slot then STOPs; rdata=0x3C; ack_err=0.
//  3 Write addr=0x22, no device (SDA stays z):
//    -> ack_err=1; no data slot; busy 176 cycles; rdata unchanged.
//  4 start pulsed again at busy+50 cycles -> ignored; only one START/STOP on the bus.
//    Then a start in the done cycle -> second transaction begins.
//  5 reset asserted in DATA bit 3:
//    -> next edge SDA=z, SCL=z, busy=0, done=0, ack_err=0, rdata=0.
//    Then a clean write completes normally.
//  6 CLK_DIV=2: write 0xFF to addr 0x7F
//    -> A5 on bus replaced by FF, first byte FE; SCL period 8 clks; SDA stable whenever SCL is high.

Source files
------------

// File: rtl/i2c_master.sv
// i2c_master: single-master I2C controller, one byte per request (START, {addr,rw}, ACK, data, ACK/NACK, STOP)
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start           request pulse, sampled only while busy=0
//   rw, addr, wdata transaction parameters latched with start (rw: 0 write, 1 read)
//   rdata           last byte read (updated only by a read with address ACK)
//   busy            transaction in progress
//   done            one-cycle pulse at the STOP->IDLE transition
//   ack_err         sticky NACK flag for the last transaction
//   SDA, SCL        open-drain bus lines, driven 0 or z; SCL is never sampled
// Timing: every slot is 4 quarters of CLK_DIV clocks; SCL low in q0/q1, released in q2/q3,
// SDA sampled on the last clk of q2.
module i2c_master #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        SDA,
  inout  wire        SCL
);
  localparam int QW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP} state_t;
  state_t        r_state;
  logic [QW-1:0] r_qcnt;
  logic [1:0]    r_q;
  logic [2:0]    r_bit;
  logic          r_rw;
  logic [6:0]    r_addr;
  logic [7:0]    r_wdata;
  logic [7:0]    r_sreg;
  logic [7:0]    r_rdata;
  logic          r_ack;
  logic          r_busy;
  logic          r_done;
  logic          r_ack_err;
  logic          r_sda_lo;
  logic          r_scl_lo;
  state_t        w_nstate;
  logic          w_tick;
  logic          w_qend;
  logic          w_samp;
  logic [1:0]    w_nq;
  logic [2:0]    w_nbit;
  logic [2:0]    w_idx;
  logic [7:0]    w_abyte;
  logic          w_sda_lo;
  logic          w_scl_lo;
  // Next phase/state decode; bus levels are derived from the *next* phase so the
  // SDA/SCL flops change exactly on quarter boundaries.
  always_comb begin
    w_tick   = r_state != S_IDLE && r_qcnt == QMAX;
    w_qend   = w_tick && r_q == 2'd3;
    w_samp   = w_tick && r_q == 2'd2;
    w_nq     = w_tick ? r_q + 2'd1 : r_q;
    w_nbit   = w_qend && (r_state == S_ADDR || r_state == S_DATA) ? r_bit + 3'd1 : r_bit;
    w_nstate = r_state == S_IDLE  ? (start ? S_START : S_IDLE)
             : !w_qend            ? r_state
             : r_state == S_START ? S_ADDR
             : r_state == S_ADDR  ? (r_bit == 3'd7 ? S_AACK : S_ADDR)
             : r_state == S_AACK  ? (r_ack ? S_STOP : S_DATA)
             : r_state == S_DATA  ? (r_bit == 3'd7 ? S_DACK : S_DATA)
             : r_state == S_DACK  ? S_STOP
             : S_IDLE;
    w_idx    = ~w_nbit;
    w_abyte  = {r_addr, r_rw};
    w_sda_lo = w_nstate == S_START ? w_nq[1]
             : w_nstate == S_ADDR  ? ~w_abyte[w_idx]
             : w_nstate == S_DATA  ? ~r_rw & ~r_wdata[w_idx]
             : w_nstate == S_STOP  ? ~w_nq[1]
             : 1'b0;
    w_scl_lo = w_nstate == S_IDLE  ? 1'b0
             : w_nstate == S_START ? w_nq == 2'd3
             : w_nstate == S_STOP  ? w_nq == 2'd0
             : ~w_nq[1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_qcnt    <= '0;
      r_q       <= 2'd0;
      r_bit     <= 3'd0;
      r_rw      <= 1'b0;
      r_addr    <= 7'd0;
      r_wdata   <= 8'd0;
      r_sreg    <= 8'd0;
      r_rdata   <= 8'd0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_sda_lo  <= 1'b0;
      r_scl_lo  <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_q      <= w_nq;
      r_bit    <= w_nbit;
      r_qcnt   <= r_state == S_IDLE || w_tick ? '0 : r_qcnt + QW'(1);
      r_sda_lo <= w_sda_lo;
      r_scl_lo <= w_scl_lo;
      r_done   <= r_state == S_STOP && w_qend;
      if (r_state == S_IDLE && start) begin
        r_rw      <= rw;
        r_addr    <= addr;
        r_wdata   <= wdata;
        r_ack_err <= 1'b0;
        r_busy    <= 1'b1;
      end
      if (r_state == S_STOP && w_qend)
        r_busy <= 1'b0;
      if (w_samp)
        r_ack <= SDA;
      if (w_samp && r_state == S_DATA && r_rw)
        r_sreg <= {r_sreg[6:0], SDA};
      // Address NACK, or data NACK on a write, raises the sticky error.
      if (w_qend && r_ack && (r_state == S_AACK || (r_state == S_DACK && !r_rw)))
        r_ack_err <= 1'b1;
      if (w_qend && r_state == S_DACK && r_rw)
        r_rdata <= r_sreg;
    end
  end
  assign SDA     = r_sda_lo ? 1'b0 : 1'bz;
  assign SCL     = r_scl_lo ? 1'b0 : 1'bz;
  assign rdata   = r_rdata;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_ack_err;
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed + random I2C transactions against a bus-level slave model and reference expectations
module tb_i2c_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, start, rw, sel;
  logic [6:0] addr;
  logic [7:0] wdata;
  wire sda1, scl1, sda2, scl2;
  pullup (sda1);
  pullup (scl1);
  pullup (sda2);
  pullup (scl2);
  logic [7:0] rdata1, rdata2;
  logic busy1, busy2, done1, done2, ae1, ae2;
  i2c_master #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start & ~sel), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .busy(busy1), .done(done1), .ack_err(ae1), .SDA(sda1), .SCL(scl1));
  i2c_master #(.CLK_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .start(start & sel), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .busy(busy2), .done(done2), .ack_err(ae2), .SDA(sda2), .SCL(scl2));
  logic s_lo = 1'b0;
  assign sda1 = (!sel && s_lo) ? 1'b0 : 1'bz;
  assign sda2 = (sel && s_lo) ? 1'b0 : 1'bz;
  logic m_sda, m_scl, m_busy, m_done, m_ae;
  logic [7:0] m_rdata;
  assign m_sda   = sel ? (sda2 !== 1'b0) : (sda1 !== 1'b0);
  assign m_scl   = sel ? (scl2 !== 1'b0) : (scl1 !== 1'b0);
  assign m_busy  = sel ? busy2 : busy1;
  assign m_done  = sel ? done2 : done1;
  assign m_ae    = sel ? ae2 : ae1;
  assign m_rdata = sel ? rdata2 : rdata1;
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  // Slave configuration
  logic [6:0] dev_addr;
  logic       present, data_ack;
  logic [7:0] rbyte;
  // Bus monitor / slave: decodes START/STOP and bits on SCL rise, answers on SCL fall.
  int cyc = 0, nb = 0, n_start = 0, n_stop = 0, t_rise = 0, pmin = 0, pmax = 0;
  logic bits [0:17];
  logic s_acked = 1'b0, s_rw = 1'b0, p_sda = 1'b1, p_scl = 1'b1;
  logic [7:0] ab;
  function automatic logic [7:0] byte_at(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = bits[base+i];
    return b;
  endfunction
  always @(negedge clk) begin
    cyc++;
    if (p_scl && m_scl && p_sda && !m_sda) begin
      n_start++; nb = 0; s_lo = 1'b0; pmin = 1 << 30; pmax = 0;
    end else if (p_scl && m_scl && !p_sda && m_sda) begin
      n_stop++; s_lo = 1'b0;
    end
    if (!p_scl && m_scl) begin
      if (nb > 0 && nb < 18) begin
        if (cyc - t_rise < pmin) pmin = cyc - t_rise;
        if (cyc - t_rise > pmax) pmax = cyc - t_rise;
      end
      t_rise = cyc;
      if (nb < 18) bits[nb] = m_sda;
      nb++;
    end
    if (p_scl && !m_scl) begin
      if (nb == 8) begin
        ab = byte_at(0);
        s_rw = ab[0];
        s_acked = present && ab[7:1] == dev_addr;
      end
      s_lo = nb == 8 ? s_acked
           : (nb >= 9 && nb <= 16) ? (s_acked && s_rw && !rbyte[16-nb])
           : nb == 17 ? (s_acked && !s_rw && data_ack)
           : 1'b0;
    end
    p_scl = m_scl;
    p_sda = m_sda;
  end
  // Reference expectations
  logic [7:0] exp_rd = 8'h00;
  bit pre = 0;
  logic nx_rw;
  logic [6:0] nx_a;
  logic [7:0] nx_wd;
  task automatic txn(input logic t_rw, input logic [6:0] t_a, input logic [7:0] t_wd, input bit poke, input bit chain);
    int s0, p0, cnt, cd;
    bit acked;
    cd = sel ? 2 : 4;
    if (!pre) begin
      rw = t_rw; addr = t_a; wdata = t_wd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    s0 = n_start;
    p0 = n_stop;
    acked = present && t_a == dev_addr;
    cnt = 0;
    while (m_busy && cnt < 100 * cd) begin
      cnt++;
      start = poke && cnt == 50;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", cnt, (acked ? 80 : 44) * cd);
    chk("done_pulse", m_done, 1);
    chk("starts", n_start - s0, 1);
    chk("stops", n_stop - p0, 1);
    chk("scl_rises", nb, acked ? 19 : 10);
    chk("addr_byte", byte_at(0), {t_a, t_rw});
    chk("addr_ack", bits[8], !acked);
    if (acked) begin
      chk("data_byte", byte_at(9), t_rw ? rbyte : t_wd);
      chk("data_ack", bits[17], t_rw ? 1'b1 : !data_ack);
    end
    chk("ack_err", m_ae, !acked || (!t_rw && !data_ack));
    if (t_rw && acked) exp_rd = rbyte;
    chk("rdata", m_rdata, exp_rd);
    if (chain) begin
      rw = nx_rw; addr = nx_a; wdata = nx_wd; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_single", m_done, 0);
    pre = chain;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int w;
    reset = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'd0; wdata = 8'd0; sel = 1'b0;
    dev_addr = 7'h50; present = 1'b1; data_ack = 1'b1; rbyte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", {busy1, busy2}, 0);
    chk("rst_done", {done1, done2}, 0);
    chk("rst_ackerr", {ae1, ae2}, 0);
    chk("rst_rdata", {rdata1, rdata2}, 0);
    chk("rst_bus", {sda1 !== 1'b0, scl1 !== 1'b0, sda2 !== 1'b0, scl2 !== 1'b0}, 4'hF);
    reset = 1'b0;
    @(negedge clk);
    txn(1'b0, 7'h50, 8'hA5, 0, 0);
    rbyte = 8'h3C;
    txn(1'b1, 7'h50, 8'h00, 0, 0);
    txn(1'b0, 7'h22, 8'h99, 0, 0);
    nx_rw = 1'b1; nx_a = 7'h50; nx_wd = 8'h00; rbyte = 8'h5A;
    txn(1'b0, 7'h50, 8'h11, 1, 1);
    txn(1'b1, 7'h50, 8'h00, 0, 0);
    rw = 1'b0; addr = 7'h50; wdata = 8'hC3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (nb < 13 && w < 400) begin
      w++;
      @(negedge clk);
    end
    chk("reach_data_bit3", nb >= 13, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_sda", m_sda, 1);
    chk("abort_scl", m_scl, 1);
    chk("abort_busy", m_busy, 0);
    chk("abort_done", m_done, 0);
    chk("abort_ackerr", m_ae, 0);
    chk("abort_rdata", m_rdata, 0);
    exp_rd = 8'h00;
    reset = 1'b0;
    @(negedge clk);
    txn(1'b0, 7'h50, 8'h5E, 0, 0);
    for (int i = 0; i < 6; i++) begin
      present = $urandom_range(0, 3) != 0;
      data_ack = $urandom_range(0, 3) != 0;
      rbyte = 8'($urandom);
      txn(1'($urandom), $urandom_range(0, 1) ? 7'h50 : 7'($urandom), 8'($urandom), 0, 0);
    end
    sel = 1'b1; present = 1'b1; data_ack = 1'b1; dev_addr = 7'h7F; exp_rd = 8'h00;
    @(negedge clk);
    txn(1'b0, 7'h7F, 8'hFF, 0, 0);
    chk("scl_period_min", pmin, 8);
    chk("scl_period_max", pmax, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
